worley_point_scheduler: RTL
===========================

// Module: worley_point_scheduler
// PURPOSE
//  Per-frame sequencer for the Worley noise feature points. Holds NPTS points (pos+velocity),
//  steps all points once per frame through one shared adder/bounce unit (one point per cycle),
//  then commits a stable snapshot for the combinational distance datapath. Sits between
//  hvsync_generator (frame_start) and worley_noise_generator. Host config port for pos/vel.
// PARAMETERS
//  NPTS  4    number of feature points (power of 2, >=2); IW = $clog2(NPTS)
//  XW    10   x coordinate width
//  YW    10   y coordinate width
//  VW    4    signed velocity width (two's complement)
//  XMAX  639  largest legal x
//  YMAX  479  largest legal y
// PORTS
//  clk          in   1        pixel clock
//  rst_n        in   1        async active-low reset
//  frame_start  in   1        1-cycle pulse at start of frame (vpos wraps to 0)
//  cfg_we       in   1        config write strobe; accepted only when cfg_ready=1
//  cfg_idx      in   IW       point index to write
//  cfg_x        in   XW       new x (clamped to XMAX)
//  cfg_y        in   YW       new y (clamped to YMAX)
//  cfg_vx       in   VW       new signed x velocity
//  cfg_vy       in   VW       new signed y velocity
//  cfg_ready    out  1        1 in IDLE, else 0
//  pts_x        out  NPTS*XW  committed x, point k at [k*XW +: XW]
//  pts_y        out  NPTS*YW  committed y, point k at [k*YW +: YW]
//  busy         out  1        1 in UPDATE or COMMIT
//  overrun      out  1        sticky: frame_start seen while busy; cleared only by reset
//  frame_cnt    out  20       committed frame count, wraps 2^20-1 -> 0
// BEHAVIOUR
//  - Reset (async, all regs): point k working+committed x = (XMAX/NPTS)*k + XMAX/(2*NPTS),
//    y = YMAX/2, vx = +1, vy = +1 (k even) / -1 (k odd). Defaults: x=79,238,397,556, y=239.
//    busy=0, overrun=0, frame_cnt=0, state=IDLE. Integer division truncates.
//  - FSM IDLE -> UPDATE on frame_start; UPDATE holds i=0..NPTS-1, one point per cycle;
//    after i=NPTS-1 -> COMMIT (1 cycle) -> IDLE.
//  - UPDATE step for point i, x axis (y identical with YMAX): nx = x + sext(vx), XW+1 bits
//    signed. If 0<=nx<=XMAX: x<=nx. Else: vx<=-vx, x unchanged (bounce). vx = -2^(VW-1)
//    negates to itself; legal configs avoid it, RTL need not special-case.
//  - COMMIT: pts_x/pts_y <= working regs (all points same edge), frame_cnt <= frame_cnt+1.
//  - Latency: frame_start at edge N -> pts_*/frame_cnt change at edge N+NPTS+1; busy high
//    edges N+1..N+NPTS+1 inclusive of COMMIT cycle. pts_* never change outside COMMIT.
//  - frame_start while busy: ignored (no restart, no queue), overrun<=1.
//  - cfg_we with cfg_ready=1: writes working x/y/vx/vy of cfg_idx that edge; visible on
//    pts_* only after next COMMIT. cfg_we with cfg_ready=0: dropped, no side effect.
//  - cfg_we and frame_start same IDLE cycle: write lands, then UPDATE starts next cycle and
//    uses the written values.
//  - vx=0 / vy=0: point stationary on that axis. Point at boundary with outward velocity
//    bounces next frame without moving.
//  - Reset mid-UPDATE/COMMIT: immediate return to reset values; no partial commit.
// TESTING
//  1 Reset, no frame_start -> pts_x={556,397,238,79}, pts_y all 239, busy=0, frame_cnt=0.
//  2 One frame_start pulse -> busy 5 cycles, then point0 x=80 y=240, point1 x=239 y=238,
//    frame_cnt=1; pts_* stable during UPDATE.
//  3 cfg idx0 x=638 vx=+3 vy=0, frame_start -> x=638 vx=-3 (bounce); next frame x=635.
//  4 cfg idx2 x=1 vx=-2 -> bounce, x=1; next frame x=3; cfg_x=1000 -> clamped 639.
//  5 frame_start again 2 cycles after first -> ignored, overrun=1, frame_cnt increments by 1.
//  6 Assert rst_n=0 during UPDATE -> outputs return to test-1 values; cfg_we while busy dropped.

Source files
------------

// File: rtl/worley_point_scheduler.sv
// Per-frame feature-point sequencer for Worley noise: steps each point once per frame through a
// shared adder/bounce unit, then commits a stable snapshot for the distance datapath.
module worley_point_scheduler #(
   parameter int unsigned NPTS = 4,
   parameter int unsigned XW   = 10,
   parameter int unsigned YW   = 10,
   parameter int unsigned VW   = 4,
   parameter int unsigned XMAX = 639,
   parameter int unsigned YMAX = 479,
   localparam int unsigned IW  = $clog2(NPTS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start,
   input  logic                 cfg_we,
   input  logic [IW-1:0]        cfg_idx,
   input  logic [XW-1:0]        cfg_x,
   input  logic [YW-1:0]        cfg_y,
   input  logic [VW-1:0]        cfg_vx,
   input  logic [VW-1:0]        cfg_vy,
   output logic                 cfg_ready,
   output logic [NPTS*XW-1:0]   pts_x,
   output logic [NPTS*YW-1:0]   pts_y,
   output logic                 busy,
   output logic                 overrun,
   output logic [19:0]          frame_cnt
);

   typedef enum logic [1:0] {StIdle, StUpdate, StCommit} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q;

   logic [XW-1:0] wx_q [NPTS];
   logic [YW-1:0] wy_q [NPTS];
   logic [VW-1:0] vx_q [NPTS];
   logic [VW-1:0] vy_q [NPTS];

   function automatic logic [XW-1:0] rst_x(input int unsigned k);
      return XW'((XMAX / NPTS) * k + XMAX / (2 * NPTS));
   endfunction

   function automatic logic [VW-1:0] rst_vy(input int unsigned k);
      return (k % 2 == 1) ? {VW{1'b1}} : VW'(1);
   endfunction

   localparam logic [YW-1:0] RstY = YW'(YMAX / 2);

   // Shared step unit: position widened by one bit so under/overflow show as sign or > max.
   logic signed [XW:0] nx;
   logic signed [YW:0] ny;
   logic               x_ok, y_ok;
   logic [XW-1:0]      cfg_x_clamped;
   logic [YW-1:0]      cfg_y_clamped;

   always_comb begin
      nx   = $signed({1'b0, wx_q[idx_q]}) +
             $signed({{(XW + 1 - VW){vx_q[idx_q][VW-1]}}, vx_q[idx_q]});
      ny   = $signed({1'b0, wy_q[idx_q]}) +
             $signed({{(YW + 1 - VW){vy_q[idx_q][VW-1]}}, vy_q[idx_q]});
      x_ok = !nx[XW] && (nx[XW-1:0] <= XW'(XMAX));
      y_ok = !ny[YW] && (ny[YW-1:0] <= YW'(YMAX));
      cfg_x_clamped = (cfg_x > XW'(XMAX)) ? XW'(XMAX) : cfg_x;
      cfg_y_clamped = (cfg_y > YW'(YMAX)) ? YW'(YMAX) : cfg_y;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (frame_start) state_d = StUpdate;
         StUpdate: if (idx_q == IW'(NPTS - 1)) state_d = StCommit;
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   assign cfg_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         overrun <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= (state_q == StUpdate) ? idx_q + 1'b1 : '0;
         if (frame_start && state_q != StIdle) overrun <= 1'b1;
      end
   end

   // Working set: config writes only in idle, stepping only in update, so they never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NPTS; k++) begin
            wx_q[k] <= rst_x(k);
            wy_q[k] <= RstY;
            vx_q[k] <= VW'(1);
            vy_q[k] <= rst_vy(k);
         end
      end else if (state_q == StIdle && cfg_we) begin
         wx_q[cfg_idx] <= cfg_x_clamped;
         wy_q[cfg_idx] <= cfg_y_clamped;
         vx_q[cfg_idx] <= cfg_vx;
         vy_q[cfg_idx] <= cfg_vy;
      end else if (state_q == StUpdate) begin
         if (x_ok) wx_q[idx_q] <= nx[XW-1:0];
         else      vx_q[idx_q] <= -vx_q[idx_q];
         if (y_ok) wy_q[idx_q] <= ny[YW-1:0];
         else      vy_q[idx_q] <= -vy_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NPTS; k++) begin
            pts_x[k*XW +: XW] <= rst_x(k);
            pts_y[k*YW +: YW] <= RstY;
         end
         frame_cnt <= '0;
      end else if (state_q == StCommit) begin
         for (int k = 0; k < NPTS; k++) begin
            pts_x[k*XW +: XW] <= wx_q[k];
            pts_y[k*YW +: YW] <= wy_q[k];
         end
         frame_cnt <= frame_cnt + 20'd1;
      end
   end

endmodule
